// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag bit
// positions and the 8-bit add/subtract helper used by the datapath.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_LSL = 3'b010,
    OP_LSR = 3'b011,
    OP_ASR = 3'b100,
    OP_AND = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
  } arith_t;

  // SUB is A + ~B + 1, so the carry out means "no borrow" (A >= B unsigned)
  function automatic arith_t add_sub(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] b_op;
    logic [8:0] sum;
    arith_t     r;
    b_op  = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_op} + {8'd0, sub};
    r.res = sum[7:0];
    r.c   = sum[8];
    r.v   = (a[7] == b_op[7]) && (sum[7] != a[7]);
    return r;
  endfunction

  function automatic logic is_shift(input op_e op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Controller <-> ALU signal bundle; master is the controller, slave the ALU.
interface alu_seq_if;
  logic       SLOW_CLOCK_STRB;
  logic       alu_en;
  logic [6:0] alu_sel;
  logic [7:0] r0_data;
  logic [7:0] r1_data;
  logic [7:0] r2_data;
  logic [7:0] r3_data;
  logic [7:0] alu_bus;
  logic       alu_bus_en;
  logic [3:0] condition_flags;
  logic       alu_busy;
  logic       alu_overrun;

  modport master (
    output SLOW_CLOCK_STRB, alu_en, alu_sel, r0_data, r1_data, r2_data, r3_data,
    input  alu_bus, alu_bus_en, condition_flags, alu_busy, alu_overrun
  );

  modport slave (
    input  SLOW_CLOCK_STRB, alu_en, alu_sel, r0_data, r1_data, r2_data, r3_data,
    output alu_bus, alu_bus_en, condition_flags, alu_busy, alu_overrun
  );
endinterface

// File: rtl/alu_seq_shifter.sv
// Iterative one-bit-per-clock shifter: loads operand and count, then shifts
// while enabled, keeping the last bit shifted out as its carry.
module alu_shifter
  import alu_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  op_e        i_op,
  input  logic [7:0] i_data,
  input  logic [2:0] i_cnt,
  output logic [7:0] o_data,
  output logic       o_carry,
  output logic       o_last
);
  logic [7:0] r_data;
  logic [2:0] r_cnt;
  logic       r_carry;
  logic [7:0] w_next;
  logic       w_out;

  always_comb begin
    w_next = r_data;
    w_out  = r_data[0];
    case (i_op)
      OP_LSL: begin
        w_next = {r_data[6:0], 1'b0};
        w_out  = r_data[7];
      end
      OP_LSR:  w_next = {1'b0, r_data[7:1]};
      OP_ASR:  w_next = {r_data[7], r_data[7:1]};
      default: w_next = r_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= 8'd0;
      r_cnt   <= 3'd0;
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_cnt   <= i_cnt;
      r_carry <= 1'b0;
    end else if (i_en && (r_cnt != 3'd0)) begin
      r_data  <= w_next;
      r_cnt   <= r_cnt - 3'd1;
      r_carry <= w_out;
    end
  end

  assign o_data  = r_data;
  assign o_carry = r_carry;
  assign o_last  = (r_cnt == 3'd1);
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle 8-bit ALU stepped by the CPU controller; results are committed
// to the condition flags on the slow-clock strobe.
module alu_seq
  import alu_seq_pkg::*;
(
  input logic      CLK,
  input logic      ARST_L,
  alu_seq_if.slave alu
);
  state_e     r_state, w_next;
  op_e        r_op;
  logic       r_arm;
  logic [7:0] r_a, r_b, r_res;
  logic       r_c, r_v, r_c_upd, r_v_upd;
  logic [3:0] r_flags, w_flags_nxt;
  logic [7:0] w_rn, w_rm, w_res, w_result, w_sh_data;
  logic       w_start, w_is_shift, w_bus_en, w_commit, w_busy;
  logic       w_sh_carry, w_sh_last, w_c_upd, w_v_upd;
  arith_t     w_arith;

  assign w_start    = (r_state == ST_IDLE) && alu.alu_en && r_arm;
  assign w_is_shift = is_shift(r_op);
  assign w_busy     = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign w_bus_en   = (r_state == ST_DONE) && alu.alu_en;
  assign w_commit   = w_bus_en && alu.SLOW_CLOCK_STRB;
  assign w_result   = w_is_shift ? w_sh_data : r_res;
  assign w_arith    = add_sub(r_a, r_b, r_op == OP_SUB);

  always_comb begin
    w_rn = alu.r0_data;
    w_rm = alu.r0_data;
    case (alu.alu_sel[3:2])
      2'd0:    w_rn = alu.r0_data;
      2'd1:    w_rn = alu.r1_data;
      2'd2:    w_rn = alu.r2_data;
      default: w_rn = alu.r3_data;
    endcase
    case (alu.alu_sel[1:0])
      2'd0:    w_rm = alu.r0_data;
      2'd1:    w_rm = alu.r1_data;
      2'd2:    w_rm = alu.r2_data;
      default: w_rm = alu.r3_data;
    endcase
  end

  // Single-cycle result and which of C/V the op is allowed to touch
  always_comb begin
    w_res   = 8'd0;
    w_c_upd = 1'b0;
    w_v_upd = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res   = w_arith.res;
        w_c_upd = 1'b1;
        w_v_upd = 1'b1;
      end
      OP_AND: w_res = r_a & r_b;
      OP_LSL, OP_LSR, OP_ASR: begin
        w_res   = r_a;
        w_c_upd = (r_b[2:0] != 3'd0);
      end
      default: w_res = 8'd0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_LOAD;
        else         w_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (!alu.alu_en)                            w_next = ST_IDLE;
        else if (w_is_shift && (r_b[2:0] != 3'd0))  w_next = ST_SHIFT;
        else                                        w_next = ST_DONE;
      end
      ST_SHIFT: begin
        if (!alu.alu_en)    w_next = ST_IDLE;
        else if (w_sh_last) w_next = ST_DONE;
        else                w_next = ST_SHIFT;
      end
      ST_DONE: begin
        if (!alu.alu_en || alu.SLOW_CLOCK_STRB) w_next = ST_IDLE;
        else                                    w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_flags_nxt         = r_flags;
    w_flags_nxt[FLAG_N] = w_result[7];
    w_flags_nxt[FLAG_Z] = (w_result == 8'd0);
    if (r_c_upd) w_flags_nxt[FLAG_C] = w_is_shift ? w_sh_carry : r_c;
    else         w_flags_nxt[FLAG_C] = r_flags[FLAG_C];
    if (r_v_upd) w_flags_nxt[FLAG_V] = r_v;
    else         w_flags_nxt[FLAG_V] = r_flags[FLAG_V];
  end

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_state <= ST_IDLE;
      r_arm   <= 1'b1;
      r_flags <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_start)           r_arm <= 1'b0;
      else if (!alu.alu_en)  r_arm <= 1'b1;
      if (w_commit)          r_flags <= w_flags_nxt;
    end
  end

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_op    <= OP_ADD;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_res   <= 8'd0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_c_upd <= 1'b0;
      r_v_upd <= 1'b0;
    end else if (w_start) begin
      r_op <= op_e'(alu.alu_sel[6:4]);
      r_a  <= w_rn;
      r_b  <= w_rm;
    end else if (r_state == ST_LOAD) begin
      r_res   <= w_res;
      r_c     <= w_arith.c;
      r_v     <= w_arith.v;
      r_c_upd <= w_c_upd;
      r_v_upd <= w_v_upd;
    end
  end

  alu_shifter u_shifter (
    .i_clk   (CLK),
    .i_rst_n (ARST_L),
    .i_load  (r_state == ST_LOAD),
    .i_en    (r_state == ST_SHIFT),
    .i_op    (r_op),
    .i_data  (r_a),
    .i_cnt   (r_b[2:0]),
    .o_data  (w_sh_data),
    .o_carry (w_sh_carry),
    .o_last  (w_sh_last)
  );

  assign alu.alu_bus         = w_bus_en ? w_result : 8'd0;
  assign alu.alu_bus_en      = w_bus_en;
  assign alu.condition_flags = r_flags;
  assign alu.alu_busy        = w_busy;
  assign alu.alu_overrun     = alu.SLOW_CLOCK_STRB && w_busy;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 CLK  input  1  system clock; all state changes on its rising edge.
REQ-002 ARST_L  input  1  reset, asynchronous, active-low.
REQ-003 SLOW_CLOCK_STRB  input  1  one-CLK strobe marking the end of a CPU step; instruction commits on it.
REQ-004 alu_en  input  1  ALU operation requested by the controller for the current step.
REQ-005 alu_sel  input  7  [6:4] op: 000 ADD, 001 SUB, 010 LSL, 011 LSR, 100 ASR, 101 AND; [3:2] Rn index; [1:0] Rm index.
REQ-006 r0_data, r1_data, r2_data, r3_data  input  8 each  register file contents.
REQ-007 alu_bus  output  8  result, valid while alu_bus_en=1; 0 otherwise.
REQ-008 alu_bus_en  output  1  result valid, drive onto bus.
REQ-009 condition_flags  output  4  committed flags: [3] N, [2] Z, [1] C, [0] V.
REQ-010 alu_busy  output  1  operation started, result not yet valid.
REQ-011 alu_overrun  output  1  one-CLK pulse: strobe arrived while busy.
REQ-012 Parameter: none; datapath fixed at 8 bits, step period fixed at >=10 CLK per SLOW_CLOCK_STRB.

Function
REQ-013 FSM states IDLE, LOAD, SHIFT, DONE, clocked on CLK (not gated by strobe).
REQ-014 Internal arm bit: set whenever alu_en=0; cleared on start; start = IDLE & alu_en & arm.
REQ-015 Start: latch A=r[Rn], B=r[Rm], op; IDLE->LOAD.
REQ-016 LOAD, op ADD/SUB/AND: compute result in one CLK; ->DONE.
REQ-017 LOAD, shift op: count=B[2:0]; count=0 -> DONE, result=A; else ->SHIFT.
REQ-018 SHIFT: one bit per CLK; LSL fills 0, LSR fills 0, ASR fills bit7; count decrements; ->DONE when count reaches 0; last bit shifted out retained as shift carry.
REQ-019 Latency start->DONE: 2 CLK for ADD/SUB/AND/zero shift; 2+count CLK for shifts (max 9).
REQ-020 DONE: alu_bus_en=1 and alu_bus=result while alu_en=1; alu_busy=1 in LOAD and SHIFT only.
REQ-021 SLOW_CLOCK_STRB in DONE with alu_en=1: commit flags, ->IDLE same edge.
REQ-022 Flags: N=result[7]; Z=(result==0); ADD C=carry out, V=signed overflow; SUB C=(A>=B unsigned, no borrow), V=signed overflow; shifts C=last bit out (unchanged if count=0), V unchanged; AND C,V unchanged.
REQ-023 alu_en falls in LOAD/SHIFT/DONE: abort ->IDLE next CLK, no flag commit, alu_bus_en=0 immediately.
REQ-024 Strobe while LOAD/SHIFT: alu_overrun=1 for that CLK, no commit, FSM continues; result discarded at alu_en fall.
REQ-025 Strobe with alu_en=0 or in IDLE: no effect on flags.
REQ-026 Arithmetic modulo 256; carry from 9-bit sum.

Reset
REQ-027 ARST_L=0: state IDLE, arm=1, count=0, A=B=result=0, condition_flags=0000, alu_bus=0, alu_bus_en=0, alu_busy=0, alu_overrun=0.
REQ-028 Reset mid-operation discards operation; first start permitted on first CLK after release with alu_en=1.

Structure
REQ-029 Shared package holds op encodings (ADD..AND), FSM state encoding, flag bit indices N/Z/C/V.
REQ-030 One sub-module: alu_shifter (iterative shift register + counter, done/carry out); ADD/SUB/AND inline.

Verification
REQ-031 ADD r0=0x7F, r1=0x01, sel=000_00_01 -> alu_bus=0x80 at start+2; after strobe flags N=1 Z=0 C=0 V=1.
REQ-032 SUB r2=0x05, r3=0x05 -> result 0x00, flags N=0 Z=1 C=1 V=0.
REQ-033 ASR r1=0x90, r0=0x03 -> alu_busy 4 CLK... DONE at start+5, result 0xF2, C=0; LSL 0x81 by 1 -> 0x02, C=1.
REQ-034 LSL by 0 with prior C=1 -> result=A, DONE at start+2, C stays 1.
REQ-035 Strobe 3 CLK after LSR-by-7 start -> alu_overrun pulse, flags unchanged; alu_en drop -> IDLE, alu_bus_en=0.
REQ-036 ARST_L low during SHIFT -> all outputs 0 immediately; alu_en held high across release -> fresh start, correct result.
